// File: rtl/mem_bus_if.sv
// CPU-port and slave-bus signal bundle for mem_bus_ctrl.
// master: the controller, which masters the slave bus. slave: the CPU plus slaves around it.
interface mem_bus_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic                            cpu_req;
  logic                            cpu_wr;
  logic [ADDR_WIDTH-1:0]           cpu_addr;
  logic [DATA_WIDTH-1:0]           cpu_wdata;
  logic [DATA_WIDTH-1:0]           cpu_rdata;
  logic                            cpu_ready;
  logic                            cpu_err;
  logic [ADDR_WIDTH-1:0]           err_addr;
  logic [NUM_SLAVES-1:0]           slv_sel;
  logic                            slv_we;
  logic [ADDR_WIDTH-1:0]           slv_addr;
  logic [DATA_WIDTH-1:0]           slv_wdata;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata;
  logic [NUM_SLAVES-1:0]           slv_ack;

  modport master (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    output cpu_rdata, cpu_ready, cpu_err, err_addr, slv_sel, slv_we, slv_addr, slv_wdata
  );

  modport slave (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    input  cpu_rdata, cpu_ready, cpu_err, err_addr, slv_sel, slv_we, slv_addr, slv_wdata
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Registered memory-map controller: decodes up to four base/size windows, runs a
// req/ack access with wait states and timeout, and returns data with a ready strobe.
module mem_bus_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          NUM_SLAVES = 4,
  parameter logic [31:0] BASE_0     = 32'h7FFF_EEFC,
  parameter logic [31:0] SIZE_0     = 32'h0000_1104,
  parameter logic [31:0] BASE_1     = 32'h1001_002C,
  parameter logic [31:0] SIZE_1     = 32'h0000_0010,
  parameter logic [31:0] BASE_2     = 32'h1001_0024,
  parameter logic [31:0] SIZE_2     = 32'h0000_0008,
  parameter logic [31:0] BASE_3     = 32'h0040_0000,
  parameter logic [31:0] SIZE_3     = 32'h0010_0000,
  parameter int          TIMEOUT    = 15
) (
  input logic       clk,
  input logic       reset,
  mem_bus_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef logic [ADDR_WIDTH:0] addr_ext_t;

  // One extra bit so base+size windows near the top of the map never wrap into a hit.
  localparam addr_ext_t BASE_EXT [4] = '{addr_ext_t'(BASE_0), addr_ext_t'(BASE_1),
                                         addr_ext_t'(BASE_2), addr_ext_t'(BASE_3)};
  localparam addr_ext_t SIZE_EXT [4] = '{addr_ext_t'(SIZE_0), addr_ext_t'(SIZE_1),
                                         addr_ext_t'(SIZE_2), addr_ext_t'(SIZE_3)};
  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   off_q, off_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;

  logic                    hit;
  logic [NUM_SLAVES-1:0]   hit_sel;
  logic [ADDR_WIDTH-1:0]   hit_off;
  addr_ext_t               addr_ext;
  addr_ext_t               diff;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    ack_hit;

  // Walk from the highest region down so the lowest matching index overrides.
  always_comb begin
    hit      = 1'b0;
    hit_sel  = '0;
    hit_off  = '0;
    diff     = '0;
    addr_ext = {1'b0, bus.cpu_addr};
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      diff = addr_ext - BASE_EXT[i];
      if (addr_ext >= BASE_EXT[i] && diff < SIZE_EXT[i]) begin
        hit        = 1'b1;
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
        hit_off    = diff[ADDR_WIDTH-1:0];
      end
    end
  end

  // sel_q is one-hot, so OR-ing the selected slice is the read-data mux.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) rd_mux = rd_mux | bus.slv_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign ack_hit = |(bus.slv_ack & sel_q);

  // NOTE: every *_d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    we_d       = we_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (hit) begin
            sel_d   = hit_sel;
            we_d    = bus.cpu_wr;
            off_d   = hit_off;
            wdata_d = bus.cpu_wdata;
            addr_d  = bus.cpu_addr;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            err_addr_d = bus.cpu_addr;
            ready_d    = 1'b1;
            err_d      = 1'b1;
            state_d    = RESP;
          end
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          if (!we_q) rdata_d = rd_mux;
          ready_d = 1'b1;
          sel_d   = '0;
          we_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LIMIT) begin
          err_addr_d = addr_q;
          if (!we_q) rdata_d = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          sel_d   = '0;
          we_d    = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the reset here is synchronous and clears the whole datapath, so a transaction
  // interrupted mid-ACCESS leaves no stale select, strobe or data behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      off_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_err   = err_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.slv_sel   = sel_q;
  assign bus.slv_we    = we_q;
  assign bus.slv_addr  = off_q;
  assign bus.slv_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed, table-driven bench for mem_bus_ctrl with default map plus a NUM_SLAVES=3 instance.
module tb_mem_bus_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS)) bus ();
  mem_bus_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(3))  bus3 ();

  mem_bus_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(NS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  mem_bus_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLAVES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // waits = ACCESS wait cycles before ack; -1 means the slave never acks.
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] ack_data;
    logic [3:0]  e_sel;
    logic [31:0] e_off;
    logic        e_err;
    int          e_lat;
    logic [31:0] e_rdata;
    logic [31:0] e_err_addr;
  } vec_t;

  vec_t vecs [10];

  task automatic run_txn(input vec_t v, input string tag);
    int                   lat;
    logic                 seen;
    logic [NS*DW-1:0]     rd;
    for (int j = 0; j < NS; j++)
      rd[j*DW +: DW] = v.e_sel[j] ? v.ack_data : {16'hBAD0, 16'(j)};
    @(negedge clk);
    check({tag, "_idle_ready"}, 64'(bus.cpu_ready), 64'h0);
    bus.slv_rdata = rd;
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = v.wr;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    lat  = 99;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Keep req high with a different request: it must be ignored outside IDLE.
        bus.cpu_addr  = 32'h0000_1000;
        bus.cpu_wr    = ~v.wr;
        bus.cpu_wdata = 32'hFFFF_FFFF;
        if (v.e_sel != 4'b0) begin
          check({tag, "_sel"},   64'(bus.slv_sel),   64'(v.e_sel));
          check({tag, "_off"},   64'(bus.slv_addr),  64'(v.e_off));
          check({tag, "_we"},    64'(bus.slv_we),    64'(v.wr));
          check({tag, "_wdata"}, 64'(bus.slv_wdata), 64'(v.wdata));
        end
      end
      if (bus.cpu_ready) begin
        seen = 1'b1;
        lat  = c;
      end else if (c == v.waits + 1) begin
        bus.slv_ack = v.e_sel;
      end else begin
        bus.slv_ack = ~v.e_sel;
      end
    end
    bus.cpu_req = 1'b0;
    bus.slv_ack = '0;
    check({tag, "_latency"},  64'(lat),           64'(v.e_lat));
    check({tag, "_err"},      64'(bus.cpu_err),   64'(v.e_err));
    check({tag, "_rdata"},    64'(bus.cpu_rdata), 64'(v.e_rdata));
    check({tag, "_err_addr"}, 64'(bus.err_addr),  64'(v.e_err_addr));
    check({tag, "_sel_off"},  64'(bus.slv_sel),   64'h0);
  endtask

  initial begin
    logic ready_seen;
    vec_t v_after;

    //         addr          wr    wdata         waits ack_data      sel      off           err   lat rdata         err_addr
    vecs[0] = '{32'h7FFF_EF00, 1'b0, 32'h0,        0, 32'hDEAD_BEEF, 4'b0001, 32'h4,       1'b0, 2,  32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{32'h1001_0028, 1'b1, 32'h5,        3, 32'h0BAD_0BAD, 4'b0100, 32'h4,       1'b0, 5,  32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{32'h0000_1000, 1'b0, 32'h0,       -1, 32'h0,         4'b0000, 32'h0,       1'b1, 1,  32'hDEAD_BEEF, 32'h0000_1000};
    vecs[3] = '{32'h1001_0030, 1'b0, 32'h0,       -1, 32'h0,         4'b0010, 32'h4,       1'b1, 16, 32'h0,         32'h1001_0030};
    vecs[4] = '{32'h1001_002B, 1'b0, 32'h0,        1, 32'h1111_2222, 4'b0100, 32'h7,       1'b0, 3,  32'h1111_2222, 32'h1001_0030};
    vecs[5] = '{32'h1001_002C, 1'b0, 32'h0,        0, 32'h3333_4444, 4'b0010, 32'h0,       1'b0, 2,  32'h3333_4444, 32'h1001_0030};
    vecs[6] = '{32'h7FFF_EEFB, 1'b0, 32'h0,       -1, 32'h0,         4'b0000, 32'h0,       1'b1, 1,  32'h3333_4444, 32'h7FFF_EEFB};
    vecs[7] = '{32'h7FFF_FFFF, 1'b0, 32'h0,        2, 32'h5555_6666, 4'b0001, 32'h1103,    1'b0, 4,  32'h5555_6666, 32'h7FFF_EEFB};
    vecs[8] = '{32'h0040_0000, 1'b0, 32'h0,        0, 32'h7777_8888, 4'b1000, 32'h0,       1'b0, 2,  32'h7777_8888, 32'h7FFF_EEFB};
    // Ack lands in the same cycle the counter reaches its limit: ack wins.
    vecs[9] = '{32'h004F_FFFC, 1'b1, 32'hA5A5_5A5A, 14, 32'h9999_0000, 4'b1000, 32'h000F_FFFC, 1'b0, 16, 32'h7777_8888, 32'h7FFF_EEFB};

    reset          = 1'b1;
    bus.cpu_req    = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.slv_rdata  = '0;
    bus.slv_ack    = '0;
    bus3.cpu_req   = 1'b0;
    bus3.cpu_wr    = 1'b0;
    bus3.cpu_addr  = '0;
    bus3.cpu_wdata = '0;
    bus3.slv_rdata = '0;
    bus3.slv_ack   = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",    64'(bus.cpu_ready), 64'h0);
    check("rst_err",      64'(bus.cpu_err),   64'h0);
    check("rst_rdata",    64'(bus.cpu_rdata), 64'h0);
    check("rst_err_addr", 64'(bus.err_addr),  64'h0);
    check("rst_sel",      64'(bus.slv_sel),   64'h0);
    check("rst_we",       64'(bus.slv_we),    64'h0);
    check("rst_slv_addr", 64'(bus.slv_addr),  64'h0);
    check("rst_wdata",    64'(bus.slv_wdata), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset during the second wait cycle of a RAM read.
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 32'h7FFF_EF00;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("mid_sel_before", 64'(bus.slv_sel), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_sel_after",   64'(bus.slv_sel),   64'h0);
    check("mid_ready_after", 64'(bus.cpu_ready), 64'h0);
    check("mid_rdata_after", 64'(bus.cpu_rdata), 64'h0);
    bus.slv_ack = '1;
    ready_seen  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.cpu_ready) ready_seen = 1'b1;
    end
    bus.slv_ack = '0;
    check("mid_no_ready", 64'(ready_seen), 64'h0);

    v_after = '{32'h7FFF_EF04, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 4'b0001, 32'h8, 1'b0, 3, 32'hCAFE_F00D, 32'h0};
    run_txn(v_after, "post_reset");

    // ROM window is inactive when only three regions are configured.
    @(negedge clk);
    bus3.cpu_req  = 1'b1;
    bus3.cpu_addr = 32'h0040_0000;
    @(negedge clk);
    bus3.cpu_req = 1'b0;
    check("ns3_ready",    64'(bus3.cpu_ready), 64'h1);
    check("ns3_err",      64'(bus3.cpu_err),   64'h1);
    check("ns3_sel",      64'(bus3.slv_sel),   64'h0);
    check("ns3_err_addr", 64'(bus3.err_addr),  64'h0040_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
